// File: rtl/mac_pkg.sv
// Shared instruction encoding and latency helper for the mac_col_db systolic column.
package mac_pkg;
    localparam int INST_LOAD = 0;
    localparam int INST_EXEC = 1;
    localparam int INST_SWAP = 2;
    localparam int INST_W    = 3;

    typedef logic [INST_W-1:0] inst_t;

    // Register count from i_inst[INST_EXEC] to fifo_wr.
    function automatic int mac_lat(input int pr);
        return 3 + $clog2(pr);
    endfunction
endpackage

// File: rtl/mac_add_tree.sv
// Pipelined signed adder tree: log2(n) registered levels, each one bit wider, with a valid sideband.
// MAC_COL_DB_OPISO_EN: a level register loads only when its input holds a valid sample.
module mac_add_tree #(
    parameter int w_in = 8,
    parameter int n    = 8
)(
    input  logic                              clk,
    input  logic                              reset,
    input  logic [n*w_in-1:0]                 in_data,
    input  logic                              in_vld,
    output logic signed [w_in+$clog2(n)-1:0]  out_data,
    output logic                              out_vld
);
    localparam int LV = $clog2(n);

    genvar l, j;
    generate
        for (l = 1; l <= LV; l++) begin : g_lvl
            localparam int WI = w_in + l - 1;
            localparam int WO = w_in + l;
            localparam int NO = n >> l;

            logic [2*NO*WI-1:0] src;
            logic               src_vld;
            logic [NO*WO-1:0]   sum_d;
            logic [NO*WO-1:0]   sum_q;
            logic               vld_q;

            if (l == 1) begin : g_first
                assign src     = in_data;
                assign src_vld = in_vld;
            end else begin : g_next
                assign src     = g_lvl[l-1].sum_q;
                assign src_vld = g_lvl[l-1].vld_q;
            end

            for (j = 0; j < NO; j++) begin : g_add
                logic signed [WI-1:0] a;
                logic signed [WI-1:0] b;
                assign a = src[2*j*WI +: WI];
                assign b = src[(2*j+1)*WI +: WI];
                assign sum_d[j*WO +: WO] = {a[WI-1], a} + {b[WI-1], b};
            end

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    sum_q <= '0;
                    vld_q <= 1'b0;
                end else begin
                    vld_q <= src_vld;
`ifdef MAC_COL_DB_OPISO_EN
                    if (src_vld) sum_q <= sum_d;
`else
                    sum_q <= sum_d;
`endif
                end
            end
        end
    endgenerate

    assign out_data = g_lvl[LV].sum_q;
    assign out_vld  = g_lvl[LV].vld_q;
endmodule

// File: rtl/mac_col_db.sv
// One column of the Q.K systolic array with double-buffered key banks and a pipelined dot product.
// MAC_COL_DB_OPISO_EN: product/tree registers load only on valid execute, so out holds between psums.
module mac_col_db
    import mac_pkg::*;
#(
    parameter int bw      = 4,
    parameter int pr      = 8,
    parameter int ncol    = 8,
    parameter int col_id  = 0,
    parameter int bw_psum = 2*bw + $clog2(pr)
)(
    input  logic                      clk,
    input  logic                      reset,
    input  logic [INST_W-1:0]         i_inst,
    input  logic [pr*bw-1:0]          q_in,
    output logic [pr*bw-1:0]          q_out,
    output logic [INST_W-1:0]         o_inst,
    output logic signed [bw_psum-1:0] out,
    output logic                      fifo_wr,
    output logic                      key_rdy
);
    localparam int PW    = 2*bw;
    localparam int CNT_W = (ncol > 1) ? $clog2(ncol) : 1;
    localparam logic [CNT_W-1:0] CNT_HIT = CNT_W'(ncol - 1 - col_id);

    function automatic logic signed [PW-1:0] lane_mul(input logic signed [bw-1:0] a,
                                                      input logic signed [bw-1:0] b);
        return PW'(a) * PW'(b);
    endfunction

    inst_t                 inst_q;
    logic [pr*bw-1:0]      query_q;
    logic [1:0][pr*bw-1:0] key_bank;
    logic                  active_sel;
    logic                  shadow_valid;
    logic                  load_ready;
    logic [CNT_W-1:0]      cnt;
    logic                  vld_p0;
    logic [pr*PW-1:0]      prod_d;
    logic [pr*PW-1:0]      prod_p1;
    logic                  vld_p1;

    logic                  swap_do;
    logic                  load_hit;
    logic                  cap_bank;
    logic [pr*bw-1:0]      key_act;

    // Swap resolves before capture, so a same-edge capture lands in the post-swap shadow bank.
    assign swap_do  = inst_q[INST_SWAP] & shadow_valid;
    assign load_hit = inst_q[INST_LOAD] & load_ready & (cnt == CNT_HIT);
    assign cap_bank = swap_do ? active_sel : ~active_sel;
    assign key_act  = key_bank[active_sel];

    // Stage p0: instruction/query registers, key banks and load bookkeeping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            inst_q       <= '0;
            query_q      <= '0;
            key_bank     <= '0;
            active_sel   <= 1'b0;
            shadow_valid <= 1'b0;
            load_ready   <= 1'b1;
            cnt          <= '0;
            vld_p0       <= 1'b0;
        end else begin
            inst_q <= i_inst;
            vld_p0 <= inst_q[INST_EXEC];
            if (inst_q[INST_LOAD] | inst_q[INST_EXEC]) query_q <= q_in;

            if (swap_do) begin
                active_sel   <= ~active_sel;
                shadow_valid <= 1'b0;
            end
            if (load_hit) begin
                key_bank[cap_bank] <= q_in;
                shadow_valid       <= 1'b1;
            end

            if (!inst_q[INST_LOAD]) begin
                load_ready <= 1'b1;
                cnt        <= '0;
            end else if (load_ready) begin
                if (cnt == CNT_HIT) begin
                    load_ready <= 1'b0;
                    cnt        <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

    genvar i;
    generate
        for (i = 0; i < pr; i++) begin : g_mul
            assign prod_d[i*PW +: PW] = lane_mul(query_q[i*bw +: bw], key_act[i*bw +: bw]);
        end
    endgenerate

    // Stage p1: lane products against the active key bank.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prod_p1 <= '0;
            vld_p1  <= 1'b0;
        end else begin
            vld_p1 <= vld_p0;
`ifdef MAC_COL_DB_OPISO_EN
            if (vld_p0) prod_p1 <= prod_d;
`else
            prod_p1 <= prod_d;
`endif
        end
    end

    // Stages p2..: reduction tree, final level is the registered psum.
    mac_add_tree #(
        .w_in (PW),
        .n    (pr)
    ) u_tree (
        .clk      (clk),
        .reset    (reset),
        .in_data  (prod_p1),
        .in_vld   (vld_p1),
        .out_data (out),
        .out_vld  (fifo_wr)
    );

    assign q_out   = query_q;
    assign o_inst  = inst_q;
    assign key_rdy = shadow_valid;
endmodule
